// File: rtl/router_input_ctrl.sv
// Input-port controller for a two-virtual-channel ring router.
// A global polarity picks which channel fills from upstream and which offers downstream.
module router_input_ctrl #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  si,
    output logic                  ri,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  req,
    input  logic                  ack
);

    logic [DATA_WIDTH-1:0] even_buf_q, even_buf_d;
    logic [DATA_WIDTH-1:0] odd_buf_q,  odd_buf_d;
    logic                  even_full_q, even_full_d;
    logic                  odd_full_q,  odd_full_d;

    // Next state: the input-side channel captures a flit, the output-side channel drains on ack.
    always_comb begin
        even_buf_d  = even_buf_q;
        odd_buf_d   = odd_buf_q;
        even_full_d = even_full_q;
        odd_full_d  = odd_full_q;
        if (polarity) begin
            if (si && !even_full_q) begin
                even_buf_d  = di;
                even_full_d = 1'b1;
            end
            if (ack && odd_full_q) begin
                odd_full_d = 1'b0;
            end
        end else begin
            if (si && !odd_full_q) begin
                odd_buf_d  = di;
                odd_full_d = 1'b1;
            end
            if (ack && even_full_q) begin
                even_full_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset that discards both buffered flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            even_buf_q  <= '0;
            odd_buf_q   <= '0;
            even_full_q <= 1'b0;
            odd_full_q  <= 1'b0;
        end else begin
            even_buf_q  <= even_buf_d;
            odd_buf_q   <= odd_buf_d;
            even_full_q <= even_full_d;
            odd_full_q  <= odd_full_d;
        end
    end

    // Handshake and data outputs follow polarity with no register stage.
    always_comb begin
        if (polarity) begin
            ri   = !even_full_q;
            req  = odd_full_q;
            dout = odd_buf_q;
        end else begin
            ri   = !odd_full_q;
            req  = even_full_q;
            dout = even_buf_q;
        end
    end

endmodule

// File: tb/tb_router_input_ctrl.sv
// Self-checking bench for router_input_ctrl against a channel-array reference model.
module tb_router_input_ctrl;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          si;
    logic          ri;
    logic [DW-1:0] di;
    logic [DW-1:0] dout;
    logic          req;
    logic          ack;

    int checks   = 0;
    int failures = 0;

    // Reference model: channel 0 = even, channel 1 = odd.
    logic [DW-1:0] buf_m  [2];
    bit            full_m [2];

    router_input_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .si       (si),
        .ri       (ri),
        .di       (di),
        .dout     (dout),
        .req      (req),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, then advance the model at posedge.
    task automatic cycle(input logic r, input logic p, input logic s, input logic [DW-1:0] d,
                         input logic a, input bit follow, input bit chk_en);
        int in_ch;
        int out_ch;
        @(negedge clk);
        reset    = r;
        polarity = p;
        si       = s;
        di       = d;
        ack      = a;
        #1;
        if (follow) si = ri;
        #1;
        in_ch  = p ? 0 : 1;
        out_ch = 1 - in_ch;
        if (chk_en) begin
            chk("ri",   DW'(ri),  DW'(!full_m[in_ch]));
            chk("req",  DW'(req), DW'(full_m[out_ch]));
            chk("dout", dout,     buf_m[out_ch]);
        end
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                buf_m[c]  = '0;
                full_m[c] = 1'b0;
            end
        end else begin
            if (si && !full_m[in_ch]) begin
                buf_m[in_ch]  = d;
                full_m[in_ch] = 1'b1;
            end
            if (a && full_m[out_ch]) full_m[out_ch] = 1'b0;
        end
    endtask

    initial begin
        logic [DW-1:0] rnd;
        for (int c = 0; c < 2; c++) begin
            buf_m[c]  = '0;
            full_m[c] = 1'b0;
        end
        reset = 1'b1; polarity = 1'b1; si = 1'b0; di = '0; ack = 1'b0;

        // Reset for three cycles with si asserted and polarity toggling; state unknown before the first edge.
        cycle(1'b1, 1'b1, 1'b1, DW'(64'hAA), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, DW'(64'hAA), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, DW'(64'hAA), 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_ri_const",   DW'(ri),  DW'(1));
        chk("rst_req_const",  DW'(req), DW'(0));
        chk("rst_dout_const", dout,     DW'(0));

        // Single flit: write even, read it next cycle while acking, then gone.
        cycle(1'b0, 1'b1, 1'b1, DW'(64'h1234), 1'b0, 1'b0, 1'b1);
        #1;
        chk("single_even_full", DW'(ri), DW'(0));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Backpressure: odd holds 0x55, a second flit 0x66 must be refused.
        cycle(1'b0, 1'b0, 1'b1, DW'(64'h55), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, DW'(64'h66), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("bp_odd_buf", dout, DW'(64'h55));
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Spurious ack with both channels empty.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'(i % 2), 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random stress with si following ri.
        for (int i = 0; i < 40; i++) begin
            rnd = {$urandom, $urandom};
            cycle(1'b0, 1'(i % 2), 1'b0, rnd, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        // Drain both channels, then fill even=0x11 and odd=0x22.
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, DW'(64'h11), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, DW'(64'h22), 1'b0, 1'b0, 1'b1);
        #1;
        chk("pre_rst_req_even", DW'(req), DW'(1));

        // Mid-stream reset discards both flits.
        cycle(1'b1, 1'b1, 1'b1, DW'(64'h33), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("post_rst_req", DW'(req), DW'(0));
        chk("post_rst_ri",  DW'(ri),  DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_input_ctrl.md
# router_input_ctrl

Input-port controller for a ring network-on-chip router with two virtual channels (even and odd). It holds one flit per channel and uses a global `polarity` signal to time-multiplex the channels. In each cycle one channel accepts a flit from the upstream link while the other channel offers its flit to the downstream stage. It sits between the upstream link and the router's output/switch stage.

## Interface
- `DATA_WIDTH`, default 64: flit width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `polarity`  in  1  global phase.
  - 1: even channel accepts input, odd channel drives output.
  - 0: odd channel accepts input, even channel drives output.
- `si`  in  1  send-in: upstream presents a valid flit on `di` this cycle.
- `ri`  out  1  ready-in to upstream: the input-side channel is empty.
- `di`  in  DATA_WIDTH  flit from upstream.
- `dout`  out  DATA_WIDTH  flit offered downstream.
- `req`  out  1  request downstream: the output-side channel holds a valid flit.
- `ack`  in  1  downstream consumed the offered flit.

## Operation
- State:
  - `even_buf`, `odd_buf`: DATA_WIDTH-bit flit registers.
  - `even_full`, `odd_full`: 1-bit valid flags.
- Combinational outputs, with no register stage:
  - polarity=1: `ri = !even_full`, `req = odd_full`, `dout = odd_buf`.
  - polarity=0: `ri = !odd_full`, `req = even_full`, `dout = even_buf`.
- Input side, on posedge:
  - polarity=1, `si` and `!even_full`: `even_buf <= di`, `even_full <= 1`.
  - polarity=0, `si` and `!odd_full`: `odd_buf <= di`, `odd_full <= 1`.
  - `si` while the input channel is full is ignored; the buffer is unchanged and upstream must retry.
- Output side, on posedge:
  - polarity=1, `ack` and `odd_full`: `odd_full <= 0`.
  - polarity=0, `ack` and `even_full`: `even_full <= 0`.
  - `ack` while the output channel is empty is ignored.
  - The buffer data is left unchanged on drain; only the flag clears.
- A given channel is never written and drained in the same cycle, because polarity assigns each channel to exactly one role per cycle.
- Input and output actions on opposite channels in the same cycle are independent.
- Reset:
  - Clears `even_full`, `odd_full`, `even_buf` and `odd_buf` to 0.
  - While reset is asserted, `si` and `ack` are ignored.
  - Outputs keep following the combinational rules: `ri=1`, `req=0`, `dout=0`.
- Reset mid-operation discards both buffered flits at the next edge.

## Timing
- `ri`, `req` and `dout` change combinationally with `polarity` and with state after each edge.
- Flit accepted at edge N (polarity p): `req` for it is asserted in the first following cycle where polarity is !p.
  - With polarity toggling every cycle, this is the cycle immediately after edge N (1-cycle latency).
- Flag cleared by `ack` at edge N: the channel shows `ri=1` in its next input-phase cycle.
- No throughput bubble: each channel can be refilled and drained on alternating cycles.
- Polarity held constant: the output channel drains and the input channel fills, with no cross-channel movement.

## Test plan
- **Reset:** assert reset for 3 cycles, toggling polarity, with `si=1`, `di=0xAA`.
  - Required: `ri=1`, `req=0`, `dout=0` every cycle; both full flags stay 0.
- **Single flit:** after reset, polarity=1, `si=1`, `di=0x1234`.
  - Required: `even_full=1`.
  - Next cycle (polarity=0): `req=1`, `dout=0x1234`.
  - With `ack=1` in that cycle: `req=0` the following polarity-0 cycle.
- **Backpressure:** fill odd with 0x55 (polarity=0), `ack=0`; next polarity-0 cycle `si=1`, `di=0x66`.
  - Required: `ri=0`; `odd_buf` remains 0x55.
- **Spurious ack:** `ack=1` with both channels empty for 4 cycles.
  - Required: no state change; `req=0`.
- **Random stress:** 20+ cycles, polarity toggling, random `di`/`ack`, `si` driven from `ri`.
  - Required every cycle: polarity=1 gives `req==odd_full` and `ri==!even_full`; polarity=0 gives `req==even_full` and `ri==!odd_full`.
- **Mid-stream reset:** both channels full (0x11 even, 0x22 odd), assert reset one cycle.
  - Required: both flags 0 after the edge; `req=0`, `ri=1`.
